// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues one outstanding imem request at a time,
// and holds the returned word in a one-entry IF/ID register. Optional: FETCH_MISALIGN_CHECK_EN.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module fetch_stage #(
  parameter logic [`WORDSIZE-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [`WORDSIZE-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [`WORDSIZE-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [`WORDSIZE-1:0] imem_rdata,
  input  logic                 redir_valid,
  input  logic [`WORDSIZE-1:0] redir_pc,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [`WORDSIZE-1:0] id_inst,
  output logic [`WORDSIZE-1:0] id_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic               fetch_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

  state_t                 state, state_nxt;
  logic [`WORDSIZE-1:0]   pc;
  logic                   kill;
  logic [`WORDSIZE-1:0]   redir_tgt;
  logic                   redir_bad;
  logic                   resp;

  // The PC is kept word aligned regardless of the target's low bits.
  assign redir_tgt = redir_pc & ~`WORDSIZE'h3;
  assign resp      = (state == WAIT) && imem_rvalid;
  assign imem_addr = pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_bad = redir_valid && (redir_pc[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_req && imem_ready) state_nxt = WAIT;
      WAIT:    if (imem_rvalid) state_nxt = REQ;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    // Redirect overrides everything; an un-returned request keeps us in WAIT to drain it.
    if (redir_valid) begin
      if (redir_bad)                          state_nxt = HALT;
      else if (state == WAIT && !imem_rvalid) state_nxt = WAIT;
      else                                    state_nxt = REQ;
    end
  end

  always_comb begin
    imem_req = (state == REQ) && (!id_valid || id_ready) && !redir_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      kill     <= 1'b0;
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
      id_pc    <= '0;
    end else if (redir_valid) begin
      pc       <= redir_tgt;
      kill     <= (state == WAIT) && !imem_rvalid && !redir_bad;
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else begin
      if (id_valid && id_ready) begin
        id_valid <= 1'b0;
        id_inst  <= NOP_INST;
      end
      // A load in the same edge as a consume wins, keeping the slot full.
      if (resp) begin
        if (kill) begin
          kill <= 1'b0;
        end else begin
          id_valid <= 1'b1;
          id_inst  <= imem_rdata;
          id_pc    <= pc;
          pc       <= pc + `WORDSIZE'd4;
        end
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           fetch_misalign <= 1'b0;
    else if (redir_valid) fetch_misalign <= redir_bad;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected requests and
// IF/ID outputs; monitors pop and compare on each accept and each consume.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int          checks = 0;
  int          errors = 0;
  int          grant, used, lat;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic [31:0] aq[$];
  logic [63:0] iq[$];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory only accepts as many requests as the stimulus has granted.
  assign imem_ready = (grant > used);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] inst);
    aq.push_back(a);
    iq.push_back({a, inst});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (iq.size() == 0 && aq.size() == 0) break;
    end
    chk(name, 32'(iq.size() + aq.size()), 32'h0);
  endtask

  task automatic wait_accept(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, {31'h0, got}, 32'h1);
  endtask

  task automatic wait_id_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id_valid) break;
    end
    chk(name, {31'h0, id_valid}, 32'h1);
  endtask

  // Memory model: response data is addr ^ 0BAD_0000 unless an override is armed.
  initial begin
    logic [31:0] d;
    int          l;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    used        = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && imem_req && imem_ready) begin
        d = ovr_en ? ovr_data : (imem_addr ^ 32'h0BAD_0000);
        l = lat;
        @(posedge clk); #1;
        used++;
        repeat (l - 1) begin @(posedge clk); #1; end
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_req && imem_ready) begin
      if (aq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
      end else chk("req_addr", imem_addr, aq.pop_front());
    end
  end

  always @(negedge clk) begin : id_mon
    logic [63:0] e;
    if (rst_n === 1'b1 && id_valid && id_ready && !redir_valid) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_id: got pc %h inst %h expected none", id_pc, id_inst);
      end else begin
        e = iq.pop_front();
        chk("id_pc", id_pc, e[63:32]);
        chk("id_inst", id_inst, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; id_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    grant = 0; lat = 1; ovr_en = 1'b0; ovr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_inst", id_inst, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", {31'h0, fetch_misalign}, 32'h0);
`endif

    // Straight-line fetch 0,4,8,C
    push_fetch(32'h0, 32'h0BAD_0000);
    push_fetch(32'h4, 32'h0BAD_0004);
    push_fetch(32'h8, 32'h0BAD_0008);
    push_fetch(32'hC, 32'h0BAD_000C);
    grant += 4; id_ready = 1'b1;
    step(); rst_n = 1'b1;
    wait_drain("t1_drain");
    @(negedge clk);
    chk("t1_next_addr", imem_addr, 32'h10);

    // Decode stall holds the slot and blocks requests
    step(); id_ready = 1'b0;
    push_fetch(32'h10, 32'h0BAD_0010); grant += 1;
    wait_id_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_req", {31'h0, imem_req}, 32'h0);
      chk("t2_stall_inst", id_inst, 32'h0BAD_0010);
      chk("t2_stall_pc", id_pc, 32'h10);
    end
    step(); push_fetch(32'h14, 32'h0BAD_0014); grant += 1; id_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_on_drain", {31'h0, imem_req}, 32'h1);
    wait_drain("t2_drain");

    // Redirect in WAIT, late response must be dropped
    step(); lat = 3; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    aq.push_back(32'h18); push_fetch(32'h100, 32'h0BAD_0100); grant += 2;
    wait_accept("t3_accept");
    step(); ovr_en = 1'b0; lat = 1; redir_valid = 1'b1; redir_pc = 32'h100;
    step(); redir_valid = 1'b0;
    @(negedge clk); chk("t3_w2_valid", {31'h0, id_valid}, 32'h0);
    @(negedge clk); chk("t3_w3_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk("t3_after_valid", {31'h0, id_valid}, 32'h0);
    chk("t3_after_addr", imem_addr, 32'h100);
    wait_drain("t3_drain");

    // Redirect flushes a held instruction and beats a simultaneous consume
    step(); id_ready = 1'b0; aq.push_back(32'h104); grant += 1;
    wait_id_valid("t4_valid");
    chk("t4_held_pc", id_pc, 32'h104);
    step(); redir_valid = 1'b1; redir_pc = 32'h200; id_ready = 1'b1;
    step(); redir_valid = 1'b0;
    @(negedge clk);
    chk("t4_flush_valid", {31'h0, id_valid}, 32'h0);
    chk("t4_flush_inst", id_inst, 32'h0000_0013);
    chk("t4_flush_addr", imem_addr, 32'h200);
    // Redirect coinciding with rvalid
    step(); aq.push_back(32'h200); push_fetch(32'h300, 32'h0BAD_0300); grant += 2;
    wait_accept("t4_accept");
    step(); redir_valid = 1'b1; redir_pc = 32'h300;
    step(); redir_valid = 1'b0;
    @(negedge clk);
    chk("t4_rv_req", {31'h0, imem_req}, 32'h1);
    chk("t4_rv_addr", imem_addr, 32'h300);
    wait_drain("t4_drain");

    // PC wraps at 2^32
    step(); redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step(); redir_valid = 1'b0;
    push_fetch(32'hFFFF_FFFC, 32'hF452_FFFC);
    push_fetch(32'h0, 32'h0BAD_0000);
    grant += 2;
    wait_drain("t5_drain");

    // Misaligned redirect
    step(); redir_valid = 1'b1; redir_pc = 32'h102;
    step(); redir_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    grant += 1;
    @(negedge clk); chk("t6_flag_set", {31'h0, fetch_misalign}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t6_halt_req", {31'h0, imem_req}, 32'h0);
    end
    step(); redir_valid = 1'b1; redir_pc = 32'h200;
    push_fetch(32'h200, 32'h0BAD_0200);
    step(); redir_valid = 1'b0;
    @(negedge clk);
    chk("t6_flag_clr", {31'h0, fetch_misalign}, 32'h0);
    chk("t6_addr", imem_addr, 32'h200);
`else
    push_fetch(32'h100, 32'h0BAD_0100); grant += 1;
    @(negedge clk); chk("t6_addr", imem_addr, 32'h100);
`endif
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    chk("end_queues", 32'(aq.size() + iq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
